// File: rtl/toggle_bank_arbiter.sv
// Round-robin arbiter that applies one requester's toggle mask to a shared bank per req/ack handshake.
// Optional RELEASE timeout with sticky err and per-requester blocking: `define TBA_RELEASE_TIMEOUT_EN.
module toggle_bank_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] tmask,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  err
);

    // state     | meaning
    // S_IDLE    | waiting for an eligible request while en=1
    // S_GRANT   | gnt asserted, winner's mask captured
    // S_APPLY   | bank toggled by captured mask, pointer advanced
    // S_RELEASE | ack asserted until winner drops req (or times out)
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_APPLY, S_RELEASE} state_t;

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   blocked_q, blocked_d;
    logic [WIDTH-1:0]  bank_q, bank_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [IDXW-1:0]   pick;
    logic [IDXW:0]     idx_sum;
    logic [IDXW-1:0]   idx;

`ifdef TBA_RELEASE_TIMEOUT_EN
    logic [7:0]        cnt_q, cnt_d;
`else
    logic [7:0]        unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
`endif

    // First eligible index at or above ptr, wrapping.
    always_comb begin
        eligible = req & ~blocked_q;
        found    = 1'b0;
        pick     = '0;
        idx_sum  = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_sum = {1'b0, ptr_q} + (IDXW+1)'(k);
            if (idx_sum >= (IDXW+1)'(NREQ)) begin
                idx_sum = idx_sum - (IDXW+1)'(NREQ);
            end
            idx = idx_sum[IDXW-1:0];
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        bank_d  = bank_q;
        mask_d  = mask_q;
        err_d   = err_q;
`ifdef TBA_RELEASE_TIMEOUT_EN
        blocked_d = blocked_q & req;
        cnt_d     = cnt_q;
`else
        blocked_d = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (en && found) begin
                    win_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                mask_d  = tmask[int'(win_q)*WIDTH +: WIDTH];
                state_d = S_APPLY;
            end
            S_APPLY: begin
                bank_d  = bank_q ^ mask_q;
                ptr_d   = (win_q == IDXW'(NREQ-1)) ? '0 : win_q + 1'b1;
                state_d = S_RELEASE;
`ifdef TBA_RELEASE_TIMEOUT_EN
                cnt_d   = 8'(TIMEOUT - 1);
`endif
            end
            S_RELEASE: begin
                if (!req[win_q]) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
`ifdef TBA_RELEASE_TIMEOUT_EN
                else if (cnt_q == 8'd0) begin
                    gnt_d            = '0;
                    err_d            = 1'b1;
                    blocked_d[win_q] = 1'b1;
                    state_d          = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            blocked_q <= '0;
            bank_q    <= '0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef TBA_RELEASE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            blocked_q <= blocked_d;
            bank_q    <= bank_d;
            mask_q    <= mask_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef TBA_RELEASE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign ack  = (state_q == S_RELEASE) ? gnt_q : '0;
    assign q    = bank_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Bench for toggle_bank_arbiter: transaction-timing model checked every cycle plus directed literal checks.
// Timeout scenario runs only when TBA_RELEASE_TIMEOUT_EN is defined.
module tb_toggle_bank_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;
`ifdef TBA_RELEASE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] tmask;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;
    logic                  err;

    int n_tests = 0;
    int n_fail  = 0;

    toggle_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .tmask(tmask),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t counts cycles since the grant was sampled (0 = idle, >=3 = release phase).
    int               m_t = 0;
    int               m_w = 0;
    int               m_ptr = 0;
    int               m_rel = 0;
    int               mi;
    bit               m_found;
    bit               m_on = 1'b0;
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_mask = '0;
    logic             m_err = 1'b0;
    logic [NREQ-1:0]  m_blk = '0;
    logic [NREQ-1:0]  m_old_blk;

    always @(posedge clk) begin
        if (reset) begin
            m_t = 0; m_ptr = 0; m_q = '0; m_mask = '0; m_err = 1'b0; m_blk = '0; m_on = 1'b1;
        end else begin
            m_old_blk = m_blk;
            if (TO_EN) m_blk = m_blk & req;
            if (m_t == 0) begin
                m_found = 1'b0;
                if (en) begin
                    for (int k = 0; k < NREQ; k++) begin
                        mi = (m_ptr + k) % NREQ;
                        if (!m_found && req[mi] && !m_old_blk[mi]) begin
                            m_found = 1'b1;
                            m_w = mi;
                        end
                    end
                end
                if (m_found) m_t = 1;
            end else if (m_t == 1) begin
                m_mask = tmask[m_w*WIDTH +: WIDTH];
                m_t = 2;
            end else if (m_t == 2) begin
                m_q = m_q ^ m_mask;
                m_ptr = (m_w + 1) % NREQ;
                m_rel = 0;
                m_t = 3;
            end else begin
                m_rel++;
                if (!req[m_w]) m_t = 0;
                else if (TO_EN && m_rel == TIMEOUT) begin
                    m_t = 0; m_err = 1'b1; m_blk[m_w] = 1'b1;
                end else m_t++;
            end
        end
    end

    logic [NREQ-1:0] exp_gnt, exp_ack;
    always @(negedge clk) begin
        if (m_on) begin
            exp_gnt = '0;
            exp_ack = '0;
            if (m_t > 0) exp_gnt[m_w] = 1'b1;
            if (m_t >= 3) exp_ack[m_w] = 1'b1;
            check("model_gnt",  32'(gnt),  32'(exp_gnt));
            check("model_ack",  32'(ack),  32'(exp_ack));
            check("model_q",    32'(q),    32'(m_q));
            check("model_busy", 32'(busy), 32'(m_t > 0));
            check("model_err",  32'(err),  32'(m_err));
        end
    end

    task automatic wait_ack(output int w);
        int n;
        n = 0;
        w = -1;
        while (ack == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (ack == '0) begin
            n_fail++;
            $display("FAIL ack_wait: no ack within 20 cycles at %0t", $time);
        end else begin
            for (int i = 0; i < NREQ; i++) if (ack[i]) w = i;
        end
    endtask

    int w;
    int order[4];

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        req   = NREQ'($urandom);
        tmask = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_q",    32'(q),    32'h0);
        check("rst_gnt",  32'(gnt),  32'h0);
        check("rst_ack",  32'(ack),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err",  32'(err),  32'h0);
        reset = 1'b0;
        req   = '0;
        @(negedge clk);

        // Round-robin between 0 and 3
        tmask[0*WIDTH +: WIDTH] = 8'h0F;
        tmask[3*WIDTH +: WIDTH] = 8'hF0;
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            wait_ack(w);
            order[k] = w;
            if (k < 3) begin
                req = req & ~ack;
                @(negedge clk);
                req = 4'b1001;
            end else begin
                req = '0;
            end
        end
        check("rr_order0", 32'(order[0]), 32'd0);
        check("rr_order1", 32'(order[1]), 32'd3);
        check("rr_order2", 32'(order[2]), 32'd0);
        check("rr_order3", 32'(order[3]), 32'd3);
        @(negedge clk);
        check("rr_q", 32'(q), 32'h00);

        // Single request, then repeat with en dropped mid-transaction
        tmask[1*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0010;
        @(negedge clk);
        check("single_gnt_c1", 32'(gnt), 32'b0010);
        @(negedge clk);
        @(negedge clk);
        check("single_ack_c3", 32'(ack), 32'b0010);
        check("single_q_c3",   32'(q),   32'hA5);
        req = '0;
        @(negedge clk);
        check("single_idle_gnt", 32'(gnt), 32'h0);
        req = 4'b0010;
        @(negedge clk);
        en = 1'b0;
        wait_ack(w);
        check("repeat_winner", 32'(w), 32'd1);
        check("repeat_q",      32'(q), 32'h00);
        req = '0;
        @(negedge clk);

        // Disabled, then zero mask
        req = 4'b0100;
        tmask[2*WIDTH +: WIDTH] = 8'h00;
        repeat (4) begin
            @(negedge clk);
            check("dis_busy", 32'(busy), 32'h0);
        end
        en = 1'b1;
        wait_ack(w);
        check("zero_winner", 32'(w), 32'd2);
        check("zero_q",      32'(q), 32'h00);
        req = '0;
        @(negedge clk);
        check("zero_idle_busy", 32'(busy), 32'h0);

        // Reset during GRANT
        tmask[0*WIDTH +: WIDTH] = 8'hFF;
        req = 4'b0001;
        @(negedge clk);
        check("midrst_grant", 32'(gnt), 32'b0001);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_q",    32'(q),    32'h00);
        check("midrst_gnt",  32'(gnt),  32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        check("midrst_q_later", 32'(q), 32'h00);

        // Early drop: ack is a single-cycle pulse
        tmask[3*WIDTH +: WIDTH] = 8'h3C;
        req = 4'b1000;
        @(negedge clk);
        check("early_gnt", 32'(gnt), 32'b1000);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("early_ack", 32'(ack), 32'b1000);
        check("early_q",   32'(q),   32'h3C);
        @(negedge clk);
        check("early_ack_gone", 32'(ack),  32'h0);
        check("early_busy",     32'(busy), 32'h0);

`ifdef TBA_RELEASE_TIMEOUT_EN
        tmask[0*WIDTH +: WIDTH] = 8'h11;
        tmask[1*WIDTH +: WIDTH] = 8'h22;
        req = 4'b0001;
        wait_ack(w);
        check("to_winner", 32'(w), 32'd0);
        req = 4'b0011;
        repeat (4) @(negedge clk);
        check("to_busy", 32'(busy), 32'h0);
        check("to_gnt",  32'(gnt),  32'h0);
        check("to_err",  32'(err),  32'h1);
        @(negedge clk);
        check("to_next_gnt", 32'(gnt), 32'b0010);
        wait_ack(w);
        req = '0;
        repeat (2) @(negedge clk);
        check("to_err_sticky", 32'(err), 32'h1);
        check("to_q",          32'(q),   32'h0F);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
